// File: rtl/fdiv_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fdiv_issue_ctrl_if
// Description : Bundle of the two issue-port handshakes, the result-bus
//               handshake, the flush strobe and the busy status of the
//               shared FP divide issue controller.
//   master : requester/consumer side (drives req*_valid/a/b/tag, flush,
//            res_ready; observes readies, res_*, busy)
//   slave  : controller side (fdiv_issue_ctrl)
// Revision    : 1.0 - initial release
// ============================================================================
interface fdiv_issue_ctrl_if #(
  parameter int XLEN = 32,
  parameter int TAGW = 6
);
  logic            req0_valid;
  logic            req0_ready;
  logic [XLEN-1:0] req0_a;
  logic [XLEN-1:0] req0_b;
  logic [TAGW-1:0] req0_tag;

  logic            req1_valid;
  logic            req1_ready;
  logic [XLEN-1:0] req1_a;
  logic [XLEN-1:0] req1_b;
  logic [TAGW-1:0] req1_tag;

  logic            flush;

  logic            res_valid;
  logic            res_ready;
  logic [XLEN-1:0] res_data;
  logic [TAGW-1:0] res_tag;
  logic [3:0]      res_flags;

  logic            busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_tag,
    output req1_valid, req1_a, req1_b, req1_tag,
    output flush, res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_tag, res_flags, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_tag,
    input  req1_valid, req1_a, req1_b, req1_tag,
    input  flush, res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_tag, res_flags, busy
  );
endinterface
`default_nettype wire

// File: rtl/fdiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : division / fdiv_issue_ctrl
// Description : division      - combinational IEEE-754 single-precision
//                               divider (round-to-nearest-even, subnormal
//                               inputs and results flushed to zero).
//               fdiv_issue_ctrl - round-robin issue controller that captures
//                               operands, holds them for LAT settle cycles,
//                               registers quotient/tag/flags and offers them
//                               on a valid/ready result bus.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fdiv_issue_ctrl_if.slave (requests, flush, result, busy)
// Revision    : 1.0 - initial release
// ============================================================================

module division #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero_division,
  output logic            o_exception,
  output logic            o_overflow,
  output logic            o_underflow
);
  logic        w_sign;
  logic [7:0]  w_ea, w_eb;
  logic [22:0] w_fa, w_fb;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;

  assign w_sign = i_a[31] ^ i_b[31];
  assign w_ea   = i_a[30:23];
  assign w_eb   = i_b[30:23];
  assign w_fa   = i_a[22:0];
  assign w_fb   = i_b[22:0];

  assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != 23'd0);
  assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != 23'd0);
  assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == 23'd0);
  assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == 23'd0);
  assign w_a_zero = (w_ea == 8'h00);
  assign w_b_zero = (w_eb == 8'h00);

  // Dividend mantissa is pre-shifted by 26 so the quotient always carries
  // 24 result bits plus a guard bit; the remainder feeds the sticky bit.
  logic [49:0] w_num, w_den, w_quo, w_rem;
  assign w_num = {1'b1, w_fa, 26'd0};
  assign w_den = {26'd0, 1'b1, w_fb};
  assign w_quo = w_num / w_den;
  assign w_rem = w_num % w_den;

  logic [23:0] w_mant, w_mant_n;
  logic [24:0] w_mant_r;
  logic        w_guard, w_sticky;
  logic [10:0] w_exp, w_exp_n;   // two's complement, bit 10 = negative

  always_comb begin
    if (w_quo[26]) begin
      w_mant   = w_quo[26:3];
      w_guard  = w_quo[2];
      w_sticky = (|w_quo[1:0]) | (|w_rem);
      w_exp    = {3'd0, w_ea} - {3'd0, w_eb} + 11'd127;
    end else begin
      w_mant   = w_quo[25:2];
      w_guard  = w_quo[1];
      w_sticky = w_quo[0] | (|w_rem);
      w_exp    = {3'd0, w_ea} - {3'd0, w_eb} + 11'd126;
    end
    w_mant_r = {1'b0, w_mant} + {24'd0, w_guard & (w_sticky | w_mant[0])};
    // Rounding carry out of the mantissa renormalises into the exponent.
    if (w_mant_r[24]) begin
      w_mant_n = w_mant_r[24:1];
      w_exp_n  = w_exp + 11'd1;
    end else begin
      w_mant_n = w_mant_r[23:0];
      w_exp_n  = w_exp;
    end
  end

  logic w_unused;
  assign w_unused = ^{w_quo[49:27], w_mant_n[23]};

  always_comb begin
    o_result        = '0;
    o_zero_division = 1'b0;
    o_exception     = 1'b0;
    o_overflow      = 1'b0;
    o_underflow     = 1'b0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf) || (w_a_zero && w_b_zero)) begin
      o_result    = 32'h7FC0_0000;
      o_exception = 1'b1;
    end else if (w_a_inf) begin
      o_result = {w_sign, 8'hFF, 23'd0};
    end else if (w_b_zero) begin
      o_result        = {w_sign, 8'hFF, 23'd0};
      o_zero_division = 1'b1;
    end else if (w_b_inf || w_a_zero) begin
      o_result = {w_sign, 31'd0};
    end else if (w_exp_n[10] || (w_exp_n == 11'd0)) begin
      o_result    = {w_sign, 31'd0};
      o_underflow = 1'b1;
    end else if (w_exp_n >= 11'd255) begin
      o_result   = {w_sign, 8'hFF, 23'd0};
      o_overflow = 1'b1;
    end else begin
      o_result = {w_sign, w_exp_n[7:0], w_mant_n[22:0]};
    end
  end
endmodule

module fdiv_issue_ctrl #(
  parameter int XLEN = 32,   // only 32 (IEEE-754 single) is supported
  parameter int TAGW = 6,
  parameter int LAT  = 8     // divider settle cycles, 1..255
) (
  input  logic                clk,
  input  logic                rst_n,
  fdiv_issue_ctrl_if.slave    bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] c_CNT_LOAD = 8'(LAT - 1);

  state_t          r_state;
  logic [7:0]      r_cnt;
  logic            r_last_grant;
  logic [XLEN-1:0] r_a_q, r_b_q;
  logic [TAGW-1:0] r_tag_q;
  logic            r_res_valid;
  logic [XLEN-1:0] r_res_data;
  logic [TAGW-1:0] r_res_tag;
  logic [3:0]      r_res_flags;
  logic            r_busy;

  logic [XLEN-1:0] w_div_result;
  logic            w_div_zd, w_div_exc, w_div_ovf, w_div_unf;

  // The divider sees only the frozen operand registers; its output is a
  // multicycle path sampled solely in the counter-zero capture cycle.
  division #(.XLEN(XLEN)) u_division (
    .i_a             (r_a_q),
    .i_b             (r_b_q),
    .o_result        (w_div_result),
    .o_zero_division (w_div_zd),
    .o_exception     (w_div_exc),
    .o_overflow      (w_div_ovf),
    .o_underflow     (w_div_unf)
  );

  // rst_n is folded in so the readies read 0 while reset is held.
  logic w_idle_open, w_grant0, w_grant1, w_acc0, w_acc1;
  assign w_idle_open = rst_n & ~bus.flush & (r_state == S_IDLE);
  // last_grant = 1 means requester 1 won last time, so requester 0 has priority.
  assign w_grant0 = bus.req0_valid & (~bus.req1_valid |  r_last_grant);
  assign w_grant1 = bus.req1_valid & (~bus.req0_valid | ~r_last_grant);
  assign w_acc0   = w_idle_open & w_grant0;
  assign w_acc1   = w_idle_open & w_grant1;

  assign bus.req0_ready = w_acc0;
  assign bus.req1_ready = w_acc1;
  assign bus.res_valid  = r_res_valid;
  assign bus.res_data   = r_res_data;
  assign bus.res_tag    = r_res_tag;
  assign bus.res_flags  = r_res_flags;
  assign bus.busy       = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_a_q        <= '0;
      r_b_q        <= '0;
      r_tag_q      <= '0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_tag    <= '0;
      r_res_flags  <= '0;
      r_busy       <= 1'b0;
    end else if (bus.flush) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc0 | w_acc1) begin
            r_a_q        <= w_acc1 ? bus.req1_a   : bus.req0_a;
            r_b_q        <= w_acc1 ? bus.req1_b   : bus.req0_b;
            r_tag_q      <= w_acc1 ? bus.req1_tag : bus.req0_tag;
            r_last_grant <= w_acc1;
            r_cnt        <= c_CNT_LOAD;
            r_state      <= S_CALC;
            r_busy       <= 1'b1;
          end
        end
        S_CALC: begin
          if (r_cnt == 8'd0) begin
            r_res_data  <= w_div_result;
            r_res_tag   <= r_tag_q;
            r_res_flags <= {w_div_zd, w_div_exc, w_div_ovf, w_div_unf};
            r_res_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_DONE: begin
          // Returning to IDLE here; the next accept waits one more cycle.
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: doc/fdiv_issue_ctrl.md
# fdiv_issue_ctrl

Issue controller for the shared single-precision floating-point `division` unit in the FP execute stage. It arbitrates between two requesters (FP reservation-station issue ports) with round-robin fairness and captures the operands. It then holds them stable for a fixed multicycle window while the combinational divider settles. Finally it registers the quotient, tag and exception flags and presents them to the common data bus through a valid/ready handshake, with a synchronous flush for mispredict recovery.

## Interface
- `XLEN`, 32: operand/result width; only 32 (IEEE-754 single) is supported.
- `TAGW`, 6: destination ROB/physical tag width.
- `LAT`, 8: cycles the divider path is given to settle; legal range 1..255. Constrained as a multicycle path.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_ready` out 1: requester 0 accepted this cycle.
- `req0_a`, `req0_b` in XLEN: dividend, divisor.
- `req0_tag` in TAGW: destination tag.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_tag`: same as requester 0, for requester 1.
- `flush` in 1: synchronous kill of all in-flight work.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer takes the result.
- `res_data` out XLEN: quotient.
- `res_tag` out TAGW: tag of the result.
- `res_flags` out 4: {zero_division, Exception, Overflow, Underflow} from the divider.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states are IDLE, CALC and DONE. Reset puts the FSM in IDLE and `last_grant`=1, so requester 0 wins first.
- All outputs reset to 0: `res_valid`, `res_data`, `res_tag`, `res_flags`, `busy`, both readies.
- Arbitration in IDLE:
  - If exactly one `reqN_valid` is high, that requester is granted.
  - If both are high, the requester ≠ `last_grant` is granted.
  - `reqN_ready` = IDLE & ~`flush` & grantN; it may depend combinationally on `valid`.
- Accept (valid & ready):
  - `a_q`, `b_q` and `tag_q` are loaded from the granted requester.
  - `last_grant` is set to N.
  - The counter loads LAT-1 and the FSM goes to CALC.
- CALC:
  - `a_q`/`b_q` drive one internal `division` instance and stay frozen.
  - The counter decrements each cycle.
  - When the counter is 0, the divider `result` and its four flags are registered into `res_*`, `res_tag` takes `tag_q`, and the FSM goes to DONE.
- DONE:
  - `res_valid`=1; `res_data`/`res_tag`/`res_flags` are held stable.
  - On `res_ready`, the FSM returns to IDLE. No new accept happens in that same cycle.
- Flush has priority over everything:
  - From any state, the next state is IDLE and `res_valid` goes to 0.
  - The counter clears; `last_grant` is unchanged.
  - Readies are forced low in the flush cycle.
- The divider result is never consumed outside the counter-0 capture cycle. Operand registers change only on accept.
- One operation is in flight at a time; there is no pipelining.

## Timing
- An accept at edge E0 means `res_valid` rises at edge E0+LAT, i.e. LAT cycles of settle time.
- The minimum accept-to-accept interval is LAT+2 cycles with `res_ready` held high: CALC for LAT cycles, DONE for 1 cycle, IDLE for 1 cycle.
- With LAT=1, CALC lasts exactly one cycle.
- Reset asserted mid-operation asynchronously clears all state and outputs. The first accept is possible in the first cycle after deassertion.
- `flush` together with `res_ready` in DONE: flush wins, and the result is dropped silently.
- `busy` is registered and equals (state≠IDLE).

## Test plan
- `req0`: 0x41200000 / 0x40000000, tag 0x03, `res_ready`=1 → `res_valid` at accept+8; `res_data`=0x40A00000, `res_tag`=0x03, `res_flags`=0000.
- Both valid in the same cycle: `req0`=0x40F00000/0x40400000 tag 5, `req1`=0x3F800000/0x00000000 tag 9 → req0 is served first, giving 0x40200000 with flags 0000. Req1 is served next with `res_tag`=9 and flags[3]=1. `req1_ready` is low until req0 completes.
- Backpressure: `res_ready` held low for 5 cycles in DONE → `res_valid` stays high, data/tag/flags stay constant, both readies stay 0, and after one `res_ready` pulse the FSM returns to IDLE.
- Flush at cycle 3 of CALC (0xC1000000/0x40000000) → `res_valid` never asserts. The next request is accepted 1 cycle later and yields 0xC0800000 (sign correct).
- Flags: 0x00800000/0x7F7FFFFF → flags[0]=1 (Underflow); 0x7FC00001/0x40400000 → flags[2]=1 (Exception).
- Reset: `rst_n` low mid-CALC → all outputs 0 immediately and `busy`=0. A fairness check after release: with both requesters held valid continuously, grants alternate 0,1,0,1.
